// File: rtl/pipe_dist_ram.sv
// Single-port distributed RAM with a PIPE_STAGES-deep read pipeline, a clock enable and per-read valid tracking.
// Optional per-word even parity with error injection is enabled by defining PIPE_DIST_RAM_PARITY_EN.
module pipe_dist_ram #(
   parameter int DATA_W      = 4,
   parameter int ADDR_W      = 9,
   parameter int PIPE_STAGES = 2,
   parameter int RW_MODE     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] di,
`ifdef PIPE_DIST_RAM_PARITY_EN
   input  logic              par_inj,
`endif
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid
`ifdef PIPE_DIST_RAM_PARITY_EN
   ,
   output logic              par_err
`endif
);

   localparam int DEPTH = 1 << ADDR_W;
`ifdef PIPE_DIST_RAM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int WORD_W = DATA_W + PAR_W;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;
   logic              issue;
   logic [WORD_W-1:0] data_p [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] vld_p;

`ifdef PIPE_DIST_RAM_PARITY_EN
   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   assign wr_word = {even_par(di) ^ par_inj, di};
`else
   assign wr_word = di;
`endif

   assign rd_word = mem[addr];
   // In write-blocks-read mode a colliding write turns the read slot into a bubble.
   assign issue   = re && ((RW_MODE != 0) || !we);

   // Array: not reset; writes are suppressed while reset is asserted or stalled.
   always_ff @(posedge clk) begin
      if (rst_n && ce && we) begin
         mem[addr] <= wr_word;
      end
   end

   // Read pipeline stages 1..PIPE_STAGES
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            data_p[k] <= '0;
         end
      end else if (ce) begin
         data_p[0] <= rd_word;
         vld_p[0]  <= issue;
         for (int k = 1; k < PIPE_STAGES; k++) begin
            data_p[k] <= data_p[k-1];
            vld_p[k]  <= vld_p[k-1];
         end
      end
   end

   assign dout     = data_p[PIPE_STAGES-1][DATA_W-1:0];
   assign rd_valid = vld_p[PIPE_STAGES-1];

`ifdef PIPE_DIST_RAM_PARITY_EN
   logic [WORD_W-1:0] last_in;
   logic              last_vld;

   generate
      if (PIPE_STAGES == 1) begin : g_par_one
         assign last_in  = rd_word;
         assign last_vld = issue;
      end else begin : g_par_many
         assign last_in  = data_p[PIPE_STAGES-2];
         assign last_vld = vld_p[PIPE_STAGES-2];
      end
   endgenerate

   // Parity check on the word entering the last stage so the flag lands with dout.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_err <= 1'b0;
      end else if (ce) begin
         par_err <= last_vld && (^last_in);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_dist_ram.sv
// Bench for pipe_dist_ram: directed vector table plus randomized traffic against a scheduled-read model.
// Two instances (write-blocks-read and read-first) share every input.
module tb_pipe_dist_ram;

   localparam int DW = 4;
   localparam int AW = 9;
   localparam int N  = 2;

   logic          clk = 1'b0;
   logic          rst_n, ce, we, re;
   logic [AW-1:0] addr;
   logic [DW-1:0] di;
   logic          par_inj;
   logic [DW-1:0] dout0, dout1;
   logic          rd_valid0, rd_valid1;
`ifdef PIPE_DIST_RAM_PARITY_EN
   logic          par_err0, par_err1;
`endif

   always #5 clk = ~clk;

   pipe_dist_ram #(.DATA_W(DW), .ADDR_W(AW), .PIPE_STAGES(N), .RW_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .re(re), .addr(addr), .di(di),
`ifdef PIPE_DIST_RAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err0),
`endif
      .dout(dout0), .rd_valid(rd_valid0));

   pipe_dist_ram #(.DATA_W(DW), .ADDR_W(AW), .PIPE_STAGES(N), .RW_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .we(we), .re(re), .addr(addr), .di(di),
`ifdef PIPE_DIST_RAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err1),
`endif
      .dout(dout1), .rd_valid(rd_valid1));

   int nvec = 0;
   int nerr = 0;

   // Reference model: array contents plus a list of outstanding reads with the
   // enabled-edge index at which each one is due on the outputs.
   typedef struct {
      int            m;
      int            due;
      logic [DW-1:0] d;
      bit            perr;
   } pend_t;

   logic [DW-1:0] mem_m [1<<AW];
   bit            par_m [1<<AW];
   pend_t         pend[$];
   int            en_cnt = 0;
   bit            ev [2];
   logic [DW-1:0] ed [2];
   bit            known [2];
   bit            ep [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit c, input bit w, input bit rd,
                             input logic [AW-1:0] a, input logic [DW-1:0] d, input bit pi);
      if (!r) begin
         pend.delete();
         for (int m = 0; m < 2; m++) begin
            ev[m] = 0; ed[m] = '0; known[m] = 1; ep[m] = 0;
         end
      end else if (c) begin
         en_cnt++;
         for (int m = 0; m < 2; m++) begin
            if (rd && (m == 1 || !w))
               pend.push_back('{m, en_cnt + N - 1, mem_m[a], (par_m[a] != ^mem_m[a])});
         end
         for (int m = 0; m < 2; m++) begin
            int hit = -1;
            foreach (pend[i]) if (hit < 0 && pend[i].m == m && pend[i].due == en_cnt) hit = i;
            if (hit >= 0) begin
               ev[m] = 1; ed[m] = pend[hit].d; known[m] = 1; ep[m] = pend[hit].perr;
               pend.delete(hit);
            end else begin
               ev[m] = 0; known[m] = 0; ep[m] = 0;
            end
         end
         if (w) begin
            mem_m[a] = d;
            par_m[a] = (^d) ^ pi;
         end
      end
   endtask

   task automatic step(input bit r, input bit c, input bit w, input bit rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit pi);
      rst_n = r; ce = c; we = w; re = rd; addr = a; di = d; par_inj = pi;
      @(posedge clk);
      model_edge(r, c, w, rd, a, d, pi);
      #1;
      check("model rd_valid mode0", {31'd0, rd_valid0}, {31'd0, ev[0]});
      check("model rd_valid mode1", {31'd0, rd_valid1}, {31'd0, ev[1]});
      if (known[0]) check("model dout mode0", {28'd0, dout0}, {28'd0, ed[0]});
      if (known[1]) check("model dout mode1", {28'd0, dout1}, {28'd0, ed[1]});
`ifdef PIPE_DIST_RAM_PARITY_EN
      check("model par_err mode0", {31'd0, par_err0}, {31'd0, ep[0]});
      check("model par_err mode1", {31'd0, par_err1}, {31'd0, ep[1]});
`endif
   endtask

   typedef struct {
      bit            r, c, w, rd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            ev0, cd0;
      logic [DW-1:0] ed0;
      bit            ev1, cd1;
      logic [DW-1:0] ed1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit c, bit w, bit rd, logic [AW-1:0] a, logic [DW-1:0] d,
                               bit ev0, bit cd0, logic [DW-1:0] ed0,
                               bit ev1, bit cd1, logic [DW-1:0] ed1);
      vec_t v;
      v.r = r; v.c = c; v.w = w; v.rd = rd; v.a = a; v.d = d;
      v.ev0 = ev0; v.cd0 = cd0; v.ed0 = ed0; v.ev1 = ev1; v.cd1 = cd1; v.ed1 = ed1;
      return v;
   endfunction

   // Enabled, non-reset row with identical expectations for both modes.
   task automatic add(input bit w, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit v, input logic [DW-1:0] dd);
      tbl.push_back(mk(1, 1, w, rd, a, d, v, v, dd, v, v, dd));
   endtask

   initial begin
      rst_n = 0; ce = 0; we = 0; re = 0; addr = '0; di = '0; par_inj = 0;

      // Latency / reset
      add(1, 0, 9'd5, 4'hA, 0, 4'h0);
      add(0, 1, 9'd5, 4'h0, 0, 4'h0);
      add(0, 0, 9'd0, 4'h0, 1, 4'hA);
      add(0, 0, 9'd0, 4'h0, 0, 4'h0);
      // Stream write then back-to-back reads
      for (int i = 0; i < 16; i++) add(1, 0, AW'(i), DW'(i), 0, 4'h0);
      for (int k = 0; k < 16; k++) add(0, 1, AW'(k), 4'h0, k > 0, DW'(k - 1));
      add(0, 0, 9'd0, 4'h0, 1, 4'hF);
      add(1, 0, 9'd511, 4'h7, 0, 4'h0);
      add(0, 1, 9'd511, 4'h0, 0, 4'h0);
      add(0, 0, 9'd0, 4'h0, 1, 4'h7);
      // Collision
      add(1, 0, 9'd3, 4'h1, 0, 4'h0);
      add(1, 1, 9'd3, 4'h9, 0, 4'h0);
      tbl.push_back(mk(1, 1, 0, 1, 9'd3, 4'h0, 0, 0, 4'h0, 1, 1, 4'h1));
      add(0, 0, 9'd0, 4'h0, 1, 4'h9);
      // Stall
      add(1, 0, 9'd5, 4'hA, 0, 4'h0);
      add(0, 1, 9'd5, 4'h0, 0, 4'h0);
      add(0, 1, 9'd5, 4'h0, 1, 4'hA);
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 1, 9'd5, 4'hF, 1, 1, 4'hA, 1, 1, 4'hA));
      add(0, 0, 9'd0, 4'h0, 1, 4'hA);
      add(0, 0, 9'd0, 4'h0, 0, 4'h0);
      add(0, 1, 9'd5, 4'h0, 0, 4'h0);
      add(0, 0, 9'd0, 4'h0, 1, 4'hA);
      // Mid-operation reset
      add(0, 1, 9'd3, 4'h0, 0, 4'h0);
      add(0, 1, 9'd511, 4'h0, 1, 4'h9);
      tbl.push_back(mk(0, 1, 1, 1, 9'd3, 4'hF, 0, 1, 4'h0, 0, 1, 4'h0));
      tbl.push_back(mk(1, 1, 0, 0, 9'd0, 4'h0, 0, 1, 4'h0, 0, 1, 4'h0));
      tbl.push_back(mk(1, 1, 0, 1, 9'd3, 4'h0, 0, 1, 4'h0, 0, 1, 4'h0));
      add(0, 0, 9'd0, 4'h0, 1, 4'h9);
      add(0, 0, 9'd0, 4'h0, 0, 4'h0);

      // Reset held for two cycles
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 0, 0, '0, '0, 0);
         check("reset rd_valid0", {31'd0, rd_valid0}, 32'd0);
         check("reset rd_valid1", {31'd0, rd_valid1}, 32'd0);
         check("reset dout0", {28'd0, dout0}, 32'd0);
         check("reset dout1", {28'd0, dout1}, 32'd0);
      end

      // Give every word a known value so random reads are predictable
      for (int i = 0; i < (1 << AW); i++) step(1, 1, 1, 0, AW'(i), DW'($urandom), 0);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].d, 0);
         check($sformatf("vec%0d rd_valid0", i), {31'd0, rd_valid0}, {31'd0, tbl[i].ev0});
         check($sformatf("vec%0d rd_valid1", i), {31'd0, rd_valid1}, {31'd0, tbl[i].ev1});
         if (tbl[i].cd0) check($sformatf("vec%0d dout0", i), {28'd0, dout0}, {28'd0, tbl[i].ed0});
         if (tbl[i].cd1) check($sformatf("vec%0d dout1", i), {28'd0, dout1}, {28'd0, tbl[i].ed1});
      end

`ifdef PIPE_DIST_RAM_PARITY_EN
      step(1, 1, 1, 0, 9'd2, 4'h6, 1);
      step(1, 1, 0, 1, 9'd2, 4'h0, 0);
      step(1, 1, 0, 0, 9'd0, 4'h0, 0);
      check("par inj dout", {28'd0, dout0}, 32'h6);
      check("par inj err", {31'd0, par_err0}, 32'd1);
      step(1, 1, 1, 0, 9'd2, 4'h6, 0);
      step(1, 1, 0, 1, 9'd2, 4'h0, 0);
      step(1, 1, 0, 0, 9'd0, 4'h0, 0);
      check("par clean err", {31'd0, par_err0}, 32'd0);
`endif

      // Randomized traffic; small address window half the time to provoke collisions
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         step($urandom_range(0, 39) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, a, DW'($urandom), $urandom_range(0, 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pipe_dist_ram.md
Name: pipe_dist_ram

Overview:
- Parametrised single-port distributed RAM with a configurable read pipeline, for wide or deep LUT-RAM buffers where read timing needs more than one register stage.
- Adds a clock enable (stall), a read strobe with a valid flag tracked through the pipeline, and a selectable read/write collision mode.
- Sits between datapath producers/consumers as a small lookup/buffer memory mapped to distributed RAM.

Parameters:
- DATA_W, 4, word width in bits (>=1)
- ADDR_W, 9, address width; depth = 2**ADDR_W
- PIPE_STAGES, 2, read pipeline register stages after the array (>=1); read latency
- RW_MODE, 0, 0 = write blocks read (no read issued when we=1); 1 = read-first (read of old contents issued in parallel with write)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- ce  in  1  clock enable; 0 freezes the array and the whole pipeline
- we  in  1  write strobe
- re  in  1  read strobe
- addr  in  ADDR_W  shared read/write address
- di  in  DATA_W  write data
- dout  out  DATA_W  read data, last pipeline stage
- rd_valid  out  1  dout holds data of an issued read

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n, sampled on the rising edge of clk.
- Reset: all pipeline data registers, including dout, go to 0. All valid bits, including rd_valid, go to 0. Array contents are not reset and are unchanged by reset.
- Reset has priority over ce. A write presented in a reset cycle is discarded, and any in-flight reads are dropped.
- Write: on an edge with rst_n=1, ce=1 and we=1, RAM[addr] <= di.
- Read issue, RW_MODE=0: issued when ce=1, re=1 and we=0. If we=1 and re=1, the write occurs, no read is issued, and a bubble (valid=0) enters stage 1.
- Read issue, RW_MODE=1: issued when ce=1 and re=1, regardless of we. With we=1 on the same address, stage 1 captures the old contents.
- Pipeline: stage registers s1..sN, where N = PIPE_STAGES, each holding a data field and a valid bit.
  - On an edge with ce=1: s1.data <= RAM[addr], s1.valid <= issued; sK <= sK-1 for K = 2..N.
  - When no read is issued, s1.data still loads RAM[addr] but valid=0. dout is don't-care while rd_valid=0.
- Outputs: dout = sN.data and rd_valid = sN.valid, both registered.
- Latency: a read sampled at edge t appears on dout/rd_valid after edge t+N-1 (N rising edges including the sampling edge), provided ce=1 on all of those edges.
- Stall: with ce=0 no state changes. The array holds, all stages hold, and dout/rd_valid hold their values. Each ce=0 cycle extends the latency by one cycle.
- Throughput: one read per enabled cycle. Back-to-back reads to any addresses produce consecutive rd_valid pulses in issue order.
- Address wrap: addr is exactly ADDR_W bits, so every value is valid and there is no out-of-range case.
- Read after write to the same address: a read issued on the edge after the write sees the new data.

Optional Feature:
- Macro: PIPE_DIST_RAM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit computed from di on write.
  - New input par_inj (1 bit): when 1 during a write, the stored parity bit is inverted.
  - New output par_err (1 bit), registered and aligned with dout: 1 when rd_valid=1 and the stored parity mismatches the parity of the stored data. Reset value 0.
  - The parity bit travels through the pipeline with its data.
- When not defined: no par_inj or par_err ports, no extra storage bit, and behaviour is otherwise identical.

Test Plan:
- Reset/latency: PIPE_STAGES=2. Hold rst_n=0 for 2 cycles -> dout=0, rd_valid=0. Write 0xA to addr 5, then read addr 5 on the next edge t -> rd_valid=1, dout=0xA after edge t+1, and rd_valid=0 the cycle after.
- Stream: write addr i <= i[3:0] for i=0..15, then read 0..15 back-to-back -> 16 consecutive rd_valid cycles with dout=0..15 in order. Also read addr 511 after writing 0x7 there -> dout=0x7.
- Collision: write addr 3 <= 0x1, then we=1, re=1, addr 3, di=0x9.
  - RW_MODE=0: no rd_valid pulse from the collision cycle.
  - RW_MODE=1: rd_valid=1 with dout=0x1, and a following read of addr 3 returns 0x9.
- Stall: issue a read of addr 5 (0xA), then drive ce=0 for 3 cycles with we=1, addr=5, di=0xF -> outputs frozen and no write happens. After ce=1 resumes, the read completes with dout=0xA and a re-read returns 0xA.
- Mid-operation reset: issue 2 reads, then assert rst_n=0 for one edge -> rd_valid=0 and dout=0 thereafter with no stale pulse. A read after reset returns the pre-reset array contents.
- With PIPE_DIST_RAM_PARITY_EN:
  - Write 0x6 to addr 2 with par_inj=1 -> reading addr 2 gives dout=0x6 with par_err=1.
  - Rewrite with par_inj=0 -> par_err=0.
